// File: rtl/uartprobe_pkg.sv
// rtl/uartprobe_pkg.sv - opcode, reply and FSM state definitions for the UART debug probe
package uartprobe_pkg;

  localparam logic [7:0] OP_PING   = 8'h00;
  localparam logic [7:0] OP_WR_GPO = 8'h01;
  localparam logic [7:0] OP_RD_GPI = 8'h02;
  localparam logic [7:0] OP_RD_GPO = 8'h03;

  localparam logic [7:0] RSP_PING = 8'h55;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_TX} state_t;

endpackage

// File: rtl/uartprobe_uart.sv
// rtl/uartprobe_uart.sv - 8N1 UART receiver and back-to-back transmitter with byte stream ports
module uartprobe_uart import uartprobe_pkg::*; #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_tdata,
  output logic       rx_tvalid,
  output logic       rx_ferr,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  output logic       tx_idle
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bitn;
  logic [7:0]    rx_sh;

  // rx_s3 is the previous synchronised sample, used only for start-edge detection
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_busy   <= 1'b0;
      rx_cnt    <= '0;
      rx_bitn   <= '0;
      rx_sh     <= '0;
      rx_tdata  <= '0;
      rx_tvalid <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      rx_tvalid <= 1'b0;
      rx_ferr   <= 1'b0;
      if (!rx_busy) begin
        if (rx_s3 && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF_M1;
          rx_bitn <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt  <= DIV_M1;
        rx_bitn <= rx_bitn + 1'b1;
        if (rx_bitn == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
        end else if (rx_bitn == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s2) begin
            rx_tdata  <= rx_sh;
            rx_tvalid <= 1'b1;
          end else begin
            rx_ferr <= 1'b1;
          end
        end else begin
          rx_sh <= {rx_s2, rx_sh[7:1]};
        end
      end
    end
  end

  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;
  logic [8:0]    tx_sh;

  // Ready on the last cycle of a stop bit so the next start bit follows with no gap
  assign tx_tready = !tx_busy || (tx_bitn == 4'd9 && tx_cnt == '0);
  assign tx_idle   = !tx_busy;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bitn <= '0;
      tx_sh   <= '1;
    end else if (tx_tvalid && tx_tready) begin
      tx      <= 1'b0;
      tx_sh   <= {1'b1, tx_tdata};
      tx_bitn <= '0;
      tx_cnt  <= DIV_M1;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_bitn == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx      <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_bitn <= tx_bitn + 1'b1;
        tx_cnt  <= DIV_M1;
      end
    end
  end

endmodule

// File: rtl/uartprobe_gpio.sv
// rtl/uartprobe_gpio.sv - UART command probe driving a GPO register and snapshotting GPI
// Define UAP_GPI_SYNC_EN to pass gpi through a 2-flop synchroniser before the snapshot.
module uartprobe_gpio import uartprobe_pkg::*; #(
  parameter int               GPO_W       = 32,
  parameter int               GPI_W       = 32,
  parameter logic [GPO_W-1:0] GPO_RESET   = '0,
  parameter int               CLK_DIV     = 868,
  parameter int               TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic [GPO_W-1:0] gpo,
  input  logic [GPI_W-1:0] gpi,
  output logic             gpo_upd,
  output logic             busy
);

  localparam int RSP_W = (GPO_W > GPI_W) ? GPO_W : GPI_W;
  localparam int NB_W  = $clog2(RSP_W / 8 + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NB_W-1:0] GPO_NB   = NB_W'(GPO_W / 8);
  localparam logic [NB_W-1:0] GPI_NB   = NB_W'(GPI_W / 8);
  localparam logic [NB_W-1:0] GPO_LAST = NB_W'(GPO_W / 8 - 1);
  localparam logic [TW-1:0]   TMO_M1   = TW'(TIMEOUT_CYC - 1);

  logic [7:0]       rx_tdata, tx_tdata;
  logic             rx_tvalid, rx_ferr, tx_tvalid, tx_tready, tx_idle;
  state_t           state;
  logic [GPO_W-1:0] stg, stg_next;
  logic [RSP_W-1:0] rsp_sh;
  logic [NB_W-1:0]  byte_cnt, rsp_left;
  logic [TW-1:0]    tmo;
  logic [GPI_W-1:0] gpi_snap;

`ifdef UAP_GPI_SYNC_EN
  logic [GPI_W-1:0] gpi_s1, gpi_s2;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      gpi_s1 <= '0;
      gpi_s2 <= '0;
    end else begin
      gpi_s1 <= gpi;
      gpi_s2 <= gpi_s1;
    end
  end
  assign gpi_snap = gpi_s2;
`else
  assign gpi_snap = gpi;
`endif

  uartprobe_uart #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk      (clk),
    .areset   (areset),
    .rx       (uart_rx),
    .tx       (uart_tx),
    .rx_tdata (rx_tdata),
    .rx_tvalid(rx_tvalid),
    .rx_ferr  (rx_ferr),
    .tx_tdata (tx_tdata),
    .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready),
    .tx_idle  (tx_idle)
  );

  // Responses are left-aligned in rsp_sh and leave MSB byte first
  assign stg_next  = (stg << 8) | GPO_W'(rx_tdata);
  assign tx_tdata  = rsp_sh[RSP_W-1 -: 8];
  assign tx_tvalid = (state == S_TX) && (rsp_left != '0);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= S_IDLE;
      gpo      <= GPO_RESET;
      gpo_upd  <= 1'b0;
      stg      <= '0;
      rsp_sh   <= '0;
      byte_cnt <= '0;
      rsp_left <= '0;
      tmo      <= '0;
    end else begin
      gpo_upd <= 1'b0;
      case (state)
        S_IDLE: if (rx_tvalid) begin
          state    <= S_TX;
          rsp_left <= NB_W'(1);
          rsp_sh   <= RSP_W'(RSP_NAK) << (RSP_W - 8);
          case (rx_tdata)
            OP_PING:   rsp_sh <= RSP_W'(RSP_PING) << (RSP_W - 8);
            OP_WR_GPO: begin
              state    <= S_WR_DATA;
              byte_cnt <= '0;
              tmo      <= '0;
            end
            OP_RD_GPI: begin
              rsp_sh   <= RSP_W'(gpi_snap) << (RSP_W - GPI_W);
              rsp_left <= GPI_NB;
            end
            OP_RD_GPO: begin
              rsp_sh   <= RSP_W'(gpo) << (RSP_W - GPO_W);
              rsp_left <= GPO_NB;
            end
            default: ;
          endcase
        end
        S_WR_DATA: begin
          if (rx_tvalid) begin
            tmo      <= '0;
            stg      <= stg_next;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == GPO_LAST) begin
              gpo      <= stg_next;
              gpo_upd  <= 1'b1;
              rsp_sh   <= RSP_W'(RSP_ACK) << (RSP_W - 8);
              rsp_left <= NB_W'(1);
              state    <= S_TX;
            end
          end else if (rx_ferr || tmo == TMO_M1) begin
            rsp_sh   <= RSP_W'(RSP_NAK) << (RSP_W - 8);
            rsp_left <= NB_W'(1);
            state    <= S_TX;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_TX: begin
          if (tx_tvalid && tx_tready) begin
            rsp_sh   <= rsp_sh << 8;
            rsp_left <= rsp_left - 1'b1;
          end else if (rsp_left == '0 && tx_idle) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
